cdc_sync_filter: RTL and testbench
==================================

CDC_SYNC_FILTER -- requirements
Module: cdc_sync_filter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk_d is the only clock, and rst_d is sampled on the rising edge of clk_d.
REQ-002 Parameter CHANNELS, default 1: number of independent single-bit channels, range 1..64.
REQ-003 Parameter SYNC_LEVELS, default 2: number of synchroniser flops per channel, range 2..4.
REQ-004 Parameter FILTER_CYCLES, default 0: extra cycles a new synchronised value must hold before it is accepted, range 0..255.
REQ-005 Parameter RST_VALUE, default all-zeros, CHANNELS bits wide: reset level of each channel.
REQ-006 Port clk_d  input  1  destination-domain clock.
REQ-007 Port rst_d  input  1  synchronous reset, active-high.
REQ-008 Port data_s  input  CHANNELS  source-domain or asynchronous levels, one bit per channel.
REQ-009 Port data_d  output  CHANNELS  filtered, synchronised level.
REQ-010 Port rise_d  output  CHANNELS  one-cycle pulse when data_d goes from 0 to 1.
REQ-011 Port fall_d  output  CHANNELS  one-cycle pulse when data_d goes from 1 to 0.
REQ-012 Port chg_d  output  CHANNELS  one-cycle pulse on any data_d change, equal to rise_d OR fall_d; used for toggle-based pulse CDC.

Function
REQ-013 Each channel SHALL pass data_s[i] through SYNC_LEVELS cascaded flops clocked by clk_d; the last stage is sq[i].
REQ-014 Each channel SHALL hold a stability counter cnt, ceil(log2(FILTER_CYCLES+1)) bits wide, minimum 1 bit.
REQ-015 On each clk_d edge, if sq[i] equals data_d[i], cnt SHALL clear to 0.
REQ-016 On each clk_d edge, if sq[i] differs from data_d[i] and cnt is less than FILTER_CYCLES, cnt SHALL increment.
REQ-017 On each clk_d edge, if sq[i] differs from data_d[i] and cnt equals FILTER_CYCLES, the channel SHALL update: data_d[i] takes sq[i] and cnt clears to 0.
REQ-018 The counter SHALL saturate at FILTER_CYCLES and never wrap.
REQ-019 Latency from the first clk_d edge that samples a new stable data_s level to the data_d change SHALL be SYNC_LEVELS+1+FILTER_CYCLES edges.
REQ-020 A deviation at sq lasting FILTER_CYCLES cycles or fewer SHALL be rejected: data_d unchanged and no pulse.
REQ-021 A deviation at sq lasting FILTER_CYCLES+1 or more cycles SHALL be accepted.
REQ-022 rise_d, fall_d and chg_d SHALL be registered and high for exactly the one cycle in which the new data_d value first appears.
REQ-023 A channel SHALL NOT produce two pulses in consecutive cycles when FILTER_CYCLES is at least 1.
REQ-024 When FILTER_CYCLES is 0, consecutive pulses in consecutive cycles are legal.
REQ-025 Channels SHALL be fully independent; simultaneous updates on several channels SHALL all be reported in the same cycle.
REQ-026 Outputs SHALL be driven only from flops; no combinational path from data_s to any output.

Reset
REQ-027 While rst_d is high at a clk_d edge, all sync stages and data_d[i] SHALL load RST_VALUE[i], cnt SHALL load 0, and rise_d, fall_d and chg_d SHALL load 0.
REQ-028 Reset mid-filter SHALL discard the pending count.
REQ-029 No pulse SHALL be generated by the reset itself.
REQ-030 No pulse SHALL be generated in the first cycle after reset release, even if data_s differs from RST_VALUE; such a difference is processed per REQ-015..REQ-021 from the first post-reset edge.

Structure
REQ-031 Per-channel logic SHALL be one sub-module, cdc_sync_filter_chan, instantiated CHANNELS times in a generate loop.
REQ-032 The parameter range limits (SYNC_LEVELS 2..4, FILTER_CYCLES max 255) and the counter-width function SHALL live in shared package cdc_pkg.
REQ-033 An out-of-range parameter SHALL cause an elaboration error.
REQ-034 The synchroniser flops SHALL carry the codebase sync-cell attribute so CDC tools recognise them.

Verification
REQ-035 CHANNELS=1, SYNC_LEVELS=2, FILTER_CYCLES=0: data_s steps 0->1 before edge E -> data_d=1 and rise_d=1 at E+2, rise_d=0 at E+3.
REQ-036 SYNC_LEVELS=3, FILTER_CYCLES=4: 4-cycle high glitch on data_s -> data_d stays 0, no pulses.
REQ-037 SYNC_LEVELS=3, FILTER_CYCLES=4: 5-cycle high glitch -> one rise_d pulse, and one fall_d pulse 5 cycles later.
REQ-038 CHANNELS=8, RST_VALUE=8'hA5: hold rst_d with data_s=8'h00, release -> data_d=8'hA5 and no pulses in the first cycle; then data_d=8'h00 and fall_d=8'hA5 for one cycle after SYNC_LEVELS+1+FILTER_CYCLES edges.
REQ-039 FILTER_CYCLES=6: assert rst_d when cnt=3 -> cnt=0, data_d=RST_VALUE, and the pending change needs a full 7 stable cycles after release.
REQ-040 Random asynchronous stimulus on 16 channels versus a reference model over 10^5 cycles -> outputs match the model, chg_d equals rise_d|fall_d, and rise_d&fall_d is never nonzero.

Source files
------------

// File: rtl/cdc_pkg.sv
// rtl/cdc_pkg.sv - shared limits and counter sizing for the sync/filter blocks
package cdc_pkg;

  localparam int CHANNELS_MIN      = 1;
  localparam int CHANNELS_MAX      = 64;
  localparam int SYNC_LEVELS_MIN   = 2;
  localparam int SYNC_LEVELS_MAX   = 4;
  localparam int FILTER_CYCLES_MAX = 255;

  // ceil(log2(filter_cycles+1)), never below one bit so a zero filter still has a counter
  function automatic int cnt_width(input int filter_cycles);
    int w;
    w = 1;
    while ((1 << w) < (filter_cycles + 1)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/cdc_sync_filter_chan.sv
// rtl/cdc_sync_filter_chan.sv - one channel: synchroniser chain, stability filter, edge pulses
module cdc_sync_filter_chan
  import cdc_pkg::*;
#(
  parameter int   SYNC_LEVELS   = 2,
  parameter int   FILTER_CYCLES = 0,
  parameter logic RST_VALUE     = 1'b0
) (
  input  logic clk_d,
  input  logic rst_d,
  input  logic data_s,
  output logic data_d,
  output logic rise_d,
  output logic fall_d,
  output logic chg_d
);

  localparam int            CW      = cnt_width(FILTER_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES);

  (* async_reg = "true" *) logic [SYNC_LEVELS-1:0] sync_q;
  logic [SYNC_LEVELS-1:0] sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   lvl_q, lvl_d;
  logic                   up_q, up_d;
  logic                   dn_q, dn_d;
  logic                   tgl_q, tgl_d;
  logic                   sq;

  assign sq = sync_q[SYNC_LEVELS-1];

  always_comb begin
    sync_d = {sync_q[SYNC_LEVELS-2:0], data_s};
    cnt_d  = '0;
    lvl_d  = lvl_q;
    // a new level is taken only once it has disagreed for FILTER_CYCLES+1 consecutive edges
    if (sq != lvl_q) begin
      if (cnt_q == CNT_MAX) begin
        lvl_d = sq;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    up_d  = lvl_d & ~lvl_q;
    dn_d  = ~lvl_d & lvl_q;
    tgl_d = lvl_d ^ lvl_q;
  end

  always_ff @(posedge clk_d) begin
    if (rst_d) begin
      sync_q <= {SYNC_LEVELS{RST_VALUE}};
      cnt_q  <= '0;
      lvl_q  <= RST_VALUE;
      up_q   <= 1'b0;
      dn_q   <= 1'b0;
      tgl_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
      up_q   <= up_d;
      dn_q   <= dn_d;
      tgl_q  <= tgl_d;
    end
  end

  assign data_d = lvl_q;
  assign rise_d = up_q;
  assign fall_d = dn_q;
  assign chg_d  = tgl_q;

endmodule

// File: rtl/cdc_sync_filter.sv
// rtl/cdc_sync_filter.sv - multi-channel level synchroniser with glitch filter and edge pulses
module cdc_sync_filter
  import cdc_pkg::*;
#(
  parameter int                  CHANNELS      = 1,
  parameter int                  SYNC_LEVELS   = 2,
  parameter int                  FILTER_CYCLES = 0,
  parameter logic [CHANNELS-1:0] RST_VALUE     = '0
) (
  input  logic                clk_d,
  input  logic                rst_d,
  input  logic [CHANNELS-1:0] data_s,
  output logic [CHANNELS-1:0] data_d,
  output logic [CHANNELS-1:0] rise_d,
  output logic [CHANNELS-1:0] fall_d,
  output logic [CHANNELS-1:0] chg_d
);

  if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX) begin : g_bad_channels
    $error("cdc_sync_filter: CHANNELS=%0d out of range", CHANNELS);
  end
  if (SYNC_LEVELS < SYNC_LEVELS_MIN || SYNC_LEVELS > SYNC_LEVELS_MAX) begin : g_bad_sync
    $error("cdc_sync_filter: SYNC_LEVELS=%0d out of range", SYNC_LEVELS);
  end
  if (FILTER_CYCLES < 0 || FILTER_CYCLES > FILTER_CYCLES_MAX) begin : g_bad_filter
    $error("cdc_sync_filter: FILTER_CYCLES=%0d out of range", FILTER_CYCLES);
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    cdc_sync_filter_chan #(
      .SYNC_LEVELS  (SYNC_LEVELS),
      .FILTER_CYCLES(FILTER_CYCLES),
      .RST_VALUE    (RST_VALUE[i])
    ) u_chan (
      .clk_d (clk_d),
      .rst_d (rst_d),
      .data_s(data_s[i]),
      .data_d(data_d[i]),
      .rise_d(rise_d[i]),
      .fall_d(fall_d[i]),
      .chg_d (chg_d[i])
    );
  end

endmodule

// File: tb/tb_cdc_sync_filter.sv
// tb/tb_cdc_sync_filter.sv - directed checks of cdc_sync_filter over four configurations
module tb_cdc_sync_filter;

  logic clk_d;
  initial clk_d = 1'b0;
  always #5 clk_d = ~clk_d;

  logic       rst_a, rst_b, rst_c, rst_e;
  logic       ds_a, dd_a, rise_a, fall_a, chg_a;
  logic       ds_b, dd_b, rise_b, fall_b, chg_b;
  logic [7:0] ds_c, dd_c, rise_c, fall_c, chg_c;
  logic       ds_e, dd_e, rise_e, fall_e, chg_e;

  int n_tests = 0;
  int n_fail  = 0;

  cdc_sync_filter #(.CHANNELS(1), .SYNC_LEVELS(2), .FILTER_CYCLES(0), .RST_VALUE(1'b0)) dut_a (
    .clk_d(clk_d), .rst_d(rst_a), .data_s(ds_a),
    .data_d(dd_a), .rise_d(rise_a), .fall_d(fall_a), .chg_d(chg_a));

  cdc_sync_filter #(.CHANNELS(1), .SYNC_LEVELS(3), .FILTER_CYCLES(4), .RST_VALUE(1'b0)) dut_b (
    .clk_d(clk_d), .rst_d(rst_b), .data_s(ds_b),
    .data_d(dd_b), .rise_d(rise_b), .fall_d(fall_b), .chg_d(chg_b));

  cdc_sync_filter #(.CHANNELS(8), .SYNC_LEVELS(2), .FILTER_CYCLES(1), .RST_VALUE(8'hA5)) dut_c (
    .clk_d(clk_d), .rst_d(rst_c), .data_s(ds_c),
    .data_d(dd_c), .rise_d(rise_c), .fall_d(fall_c), .chg_d(chg_c));

  cdc_sync_filter #(.CHANNELS(1), .SYNC_LEVELS(2), .FILTER_CYCLES(6), .RST_VALUE(1'b0)) dut_e (
    .clk_d(clk_d), .rst_d(rst_e), .data_s(ds_e),
    .data_d(dd_e), .rise_d(rise_e), .fall_d(fall_e), .chg_d(chg_e));

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_d);
    #1;
  endtask

  initial begin
    logic [7:0] e_lvl, e_rise, e_fall;

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_e = 1'b1;
    ds_a  = 1'b0; ds_b  = 1'b0; ds_c  = 8'h00; ds_e  = 1'b0;
    repeat (3) tick();
    rst_a = 1'b0; rst_b = 1'b0; rst_e = 1'b0;
    tick();
    check("a_reset_data", 8'(dd_a), 8'h00);
    check("a_reset_chg",  8'(chg_a), 8'h00);
    check("b_reset_data", 8'(dd_b), 8'h00);
    check("e_reset_data", 8'(dd_e), 8'h00);

    // unfiltered 2-flop path: a step lands on data_d at E+2
    ds_a = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      e_lvl  = 8'(k >= 2);
      e_rise = 8'(k == 2);
      check($sformatf("a_up_data k%0d", k), 8'(dd_a), e_lvl);
      check($sformatf("a_up_rise k%0d", k), 8'(rise_a), e_rise);
      check($sformatf("a_up_fall k%0d", k), 8'(fall_a), 8'h00);
      check($sformatf("a_up_chg k%0d", k), 8'(chg_a), e_rise);
    end
    ds_a = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      e_lvl  = 8'(k < 2);
      e_fall = 8'(k == 2);
      check($sformatf("a_dn_data k%0d", k), 8'(dd_a), e_lvl);
      check($sformatf("a_dn_fall k%0d", k), 8'(fall_a), e_fall);
      check($sformatf("a_dn_chg k%0d", k), 8'(chg_a), e_fall);
    end
    // one-cycle input pulse gives rise and fall on consecutive cycles
    ds_a = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 0) ds_a = 1'b0;
      check($sformatf("a_blip_data k%0d", k), 8'(dd_a), 8'(k == 2));
      check($sformatf("a_blip_rise k%0d", k), 8'(rise_a), 8'(k == 2));
      check($sformatf("a_blip_fall k%0d", k), 8'(fall_a), 8'(k == 3));
    end

    // 3-flop sync, 4-cycle filter: 4-cycle glitch rejected, 5-cycle accepted
    for (int glen = 4; glen <= 5; glen++) begin
      for (int k = 0; k < 16; k++) begin
        ds_b = (k < glen);
        tick();
        if (glen == 5) begin
          e_lvl  = 8'(k >= 7 && k < 12);
          e_rise = 8'(k == 7);
          e_fall = 8'(k == 12);
        end else begin
          e_lvl  = 8'h00;
          e_rise = 8'h00;
          e_fall = 8'h00;
        end
        check($sformatf("b_g%0d_data k%0d", glen, k), 8'(dd_b), e_lvl);
        check($sformatf("b_g%0d_rise k%0d", glen, k), 8'(rise_b), e_rise);
        check($sformatf("b_g%0d_fall k%0d", glen, k), 8'(fall_b), e_fall);
        check($sformatf("b_g%0d_chg k%0d", glen, k), 8'(chg_b), e_rise | e_fall);
      end
    end

    // 8 channels, reset value A5 with inputs held at 00
    check("c_inreset_data", dd_c, 8'hA5);
    check("c_inreset_fall", fall_c, 8'h00);
    check("c_inreset_chg",  chg_c, 8'h00);
    rst_c = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick();
      e_lvl  = (k < 3) ? 8'hA5 : 8'h00;
      e_fall = (k == 3) ? 8'hA5 : 8'h00;
      check($sformatf("c_rel_data k%0d", k), dd_c, e_lvl);
      check($sformatf("c_rel_fall k%0d", k), fall_c, e_fall);
      check($sformatf("c_rel_rise k%0d", k), rise_c, 8'h00);
      check($sformatf("c_rel_chg k%0d", k), chg_c, e_fall);
    end
    ds_c = 8'hFF;
    for (int k = 0; k < 6; k++) begin
      tick();
      e_lvl  = (k < 3) ? 8'h00 : 8'hFF;
      e_rise = (k == 3) ? 8'hFF : 8'h00;
      check($sformatf("c_all_data k%0d", k), dd_c, e_lvl);
      check($sformatf("c_all_rise k%0d", k), rise_c, e_rise);
      check($sformatf("c_all_fall k%0d", k), fall_c, 8'h00);
      check($sformatf("c_all_chg k%0d", k), chg_c, e_rise);
    end

    // 6-cycle filter: reset part-way through the count, then a full 9-edge latency
    ds_e = 1'b1;
    repeat (5) tick();
    check("e_prefilter_data", 8'(dd_e), 8'h00);
    rst_e = 1'b1;
    tick();
    check("e_midrst_data", 8'(dd_e), 8'h00);
    check("e_midrst_rise", 8'(rise_e), 8'h00);
    rst_e = 1'b0;
    for (int k = 0; k < 11; k++) begin
      tick();
      check($sformatf("e_post_data k%0d", k), 8'(dd_e), 8'(k >= 8));
      check($sformatf("e_post_rise k%0d", k), 8'(rise_e), 8'(k == 8));
      check($sformatf("e_post_fall k%0d", k), 8'(fall_e), 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
